// File: rtl/ni_port_arbiter_if.sv
// Bundle of requester-side and AXI4-Lite master-side signals for ni_port_arbiter.
// master: the arbiter. slave: the environment (core requesters plus the NI slave).
interface ni_port_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Every channel is valid/ready: a transfer happens on a cycle where both are high.
  // Once valid is raised it stays high, with its payload stable, until that transfer.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [1:0]              rsp_resp;
  logic [ADDR_W-1:0]       awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_W-1:0]       wdata;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
           awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
           awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready
  );
endinterface

// File: rtl/ni_port_arbiter.sv
// Round-robin sharing of one AXI4-Lite NI slave port among N_REQ requesters; one transaction
// in flight, and its response is returned to the requester that was granted.
module ni_port_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  ni_port_arbiter_if.master bus,
  output logic              busy,
  output logic [2:0]        grant_idx,
  output logic [2:0]        state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        last_q, grant_q, pick;
  logic              found, sel_write, rsp_ack, aw_hs, w_hs;
  logic              aw_done_q, w_done_q;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q, rdata_q;
  logic [1:0]        resp_q;

  // Search starts just after the last grant and wraps, so a requester that was just
  // served has the lowest priority on the next pick.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && bus.req_valid[i] && (i == (int'(last_q) + k) % N_REQ)) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_write     = 1'b0;
    sel_addr      = '0;
    sel_wdata     = '0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == 3'(i)) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
      bus.req_ready[i] = (state == S_IDLE) && found && (pick == 3'(i));
      bus.rsp_valid[i] = (state == S_RSP) && (grant_q == 3'(i));
    end
  end

  assign rsp_ack       = |(bus.rsp_valid & bus.rsp_ready);
  assign aw_hs         = bus.awvalid && bus.awready;
  assign w_hs          = bus.wvalid && bus.wready;
  assign bus.awvalid   = (state == S_WR) && !aw_done_q;
  assign bus.wvalid    = (state == S_WR) && !w_done_q;
  assign bus.bready    = (state == S_WRESP);
  assign bus.arvalid   = (state == S_RD);
  assign bus.rready    = (state == S_RDATA);
  assign bus.awaddr    = addr_q;
  assign bus.araddr    = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_resp  = resp_q;
  assign busy          = (state != S_IDLE);
  assign grant_idx     = grant_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = sel_write ? S_WR : S_RD;
      // AW and W complete independently; leave only once both have transferred.
      S_WR:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nxt = S_WRESP;
      S_WRESP: if (bus.bvalid) state_nxt = S_RSP;
      S_RD:    if (bus.arready) state_nxt = S_RDATA;
      S_RDATA: if (bus.rvalid) state_nxt = S_RSP;
      S_RSP:   if (rsp_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 3'(N_REQ - 1);
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && found) begin
        last_q    <= pick;
        grant_q   <= pick;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state == S_WR) begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (state == S_WRESP && bus.bvalid) begin
        rdata_q <= '0;
        resp_q  <= bus.bresp;
      end
      if (state == S_RDATA && bus.rvalid) begin
        rdata_q <= bus.rdata;
        resp_q  <= bus.rresp;
      end
    end
  end
endmodule

// File: tb/tb_ni_port_arbiter.sv
// Directed bench for ni_port_arbiter: a table of single transactions at minimum latency,
// then hand-written sequences for round-robin fairness, AW stall, held response and reset.
module tb_ni_port_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [2:0]  grant_idx;
  logic [2:0]  state_dbg;
  logic        r_en;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sl_resp;
    logic [31:0] sl_rdata;
    int          g;
  } vec_t;

  vec_t vecs[10];

  ni_port_arbiter_if #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) bus ();

  ni_port_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // slave answers B and R in the cycle the arbiter becomes ready for them
  assign bus.bvalid = bus.bready;
  assign bus.rvalid = bus.rready & r_en;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic string nm(input int idx, input string s);
    return $sformatf("v%0d_%s", idx, s);
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d);
    bus.req_addr[i*32 +: 32]  = a;
    bus.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 30; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("wait_idle_busy", busy, 0);
  endtask

  // driver: one table transaction with a zero-wait slave, checked cycle by cycle
  task automatic apply_vec(input int idx);
    vec_t        v;
    logic        wr;
    logic [3:0]  oh;
    logic [31:0] exp_rd;
    v  = vecs[idx];
    wr = v.write[v.g];
    oh = 4'b0001 << v.g;
    for (int i = 0; i < N; i++)
      set_req(i, (i == v.g) ? v.addr : (32'hBAD0_0000 | i), (i == v.g) ? v.wdata : ~v.wdata);
    bus.req_write = v.write;
    bus.req_valid = v.valid;
    bus.bresp     = v.sl_resp;
    bus.rresp     = v.sl_resp;
    bus.rdata     = v.sl_rdata;
    #1;
    chk(nm(idx, "req_ready"), bus.req_ready, oh);
    @(negedge clk);
    bus.req_valid = '0;
    if (wr) begin
      chk(nm(idx, "awvalid"), bus.awvalid, 1);
      chk(nm(idx, "wvalid"), bus.wvalid, 1);
      chk(nm(idx, "awaddr"), bus.awaddr, v.addr);
      chk(nm(idx, "wdata"), bus.wdata, v.wdata);
    end else begin
      chk(nm(idx, "arvalid"), bus.arvalid, 1);
      chk(nm(idx, "araddr"), bus.araddr, v.addr);
    end
    @(negedge clk);
    if (wr) chk(nm(idx, "bready"), bus.bready, 1);
    else    chk(nm(idx, "rready"), bus.rready, 1);
    @(negedge clk);
    exp_rd = exp_q.pop_front();
    chk(nm(idx, "rsp_valid"), bus.rsp_valid, oh);
    chk(nm(idx, "rsp_resp"), bus.rsp_resp, v.sl_resp);
    chk(nm(idx, "rsp_rdata"), bus.rsp_rdata, exp_rd);
    chk(nm(idx, "grant_idx"), grant_idx, v.g);
    @(negedge clk);
    chk(nm(idx, "idle_busy"), busy, 0);
    chk(nm(idx, "idle_rsp_valid"), bus.rsp_valid, 0);
  endtask

  initial begin
    int seen;
    int prev;
    //            valid    write    addr          wdata          resp   rdata          grant
    vecs[0] = '{4'b0001, 4'b0001, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 32'h0000_0000, 0};
    vecs[1] = '{4'b0100, 4'b0000, 32'h0000_0020, 32'h0000_0000, 2'b00, 32'hDEAD_BEEF, 2};
    vecs[2] = '{4'b1111, 4'b1010, 32'h0000_0030, 32'h1111_2222, 2'b00, 32'h0000_0000, 3};
    vecs[3] = '{4'b1111, 4'b1010, 32'h0000_0034, 32'h0000_0000, 2'b00, 32'hCAFE_0003, 0};
    vecs[4] = '{4'b1111, 4'b1010, 32'h0000_0038, 32'h3333_4444, 2'b00, 32'h0000_0000, 1};
    vecs[5] = '{4'b1111, 4'b1010, 32'h0000_003C, 32'h0000_0000, 2'b01, 32'h0000_0005, 2};
    vecs[6] = '{4'b0011, 4'b0000, 32'h0000_0080, 32'h0000_0000, 2'b00, 32'h8080_8080, 0};
    vecs[7] = '{4'b0011, 4'b0010, 32'h0000_0084, 32'h5555_AAAA, 2'b11, 32'h0000_0000, 1};
    vecs[8] = '{4'b1001, 4'b0000, 32'h0000_0088, 32'h0000_0000, 2'b10, 32'h1234_5678, 3};
    vecs[9] = '{4'b1000, 4'b1000, 32'h0000_008C, 32'h0F0F_0F0F, 2'b00, 32'h0000_0000, 3};
    for (int t = 0; t < 10; t++)
      exp_q.push_back(vecs[t].write[vecs[t].g] ? 32'h0 : vecs[t].sl_rdata);

    reset         = 1'b1;
    r_en          = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 4'hF;
    bus.awready   = 1'b1;
    bus.wready    = 1'b1;
    bus.arready   = 1'b1;
    bus.bresp     = 2'b00;
    bus.rresp     = 2'b00;
    bus.rdata     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_axi_valid_ready", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    chk("rst_addr_data", {bus.awaddr, bus.wdata}, 0);
    chk("rst_rsp_data", {bus.rsp_rdata, bus.rsp_resp}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 10; t++) apply_vec(t);

    // all four requesters held high: strict rotation, never the same one twice in a row
    bus.req_valid = 4'hF;
    bus.req_write = 4'b0101;
    bus.rdata     = 32'h0000_0077;
    bus.bresp     = 2'b00;
    bus.rresp     = 2'b00;
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      seen = -1;
      for (int c = 0; c < 20; c++) begin
        #1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) seen = i;
        @(negedge clk);
        if (seen >= 0) break;
      end
      chk($sformatf("rr_grant%0d", n), seen, n % 4);
      chk($sformatf("rr_repeat%0d", n), seen == prev, 0);
      prev = seen;
    end
    bus.req_valid = '0;
    wait_idle();

    // AW stalled three cycles while W goes through immediately
    bus.awready   = 1'b0;
    set_req(0, 32'h0000_0040, 32'hA5A5_0001);
    bus.req_write = 4'b0001;
    bus.req_valid = 4'b0001;
    #1;
    chk("aws_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    chk("aws_c1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
    @(negedge clk);
    chk("aws_c2_valids", {bus.awvalid, bus.wvalid}, 2'b10);
    @(negedge clk);
    chk("aws_c3_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    @(negedge clk);
    chk("aws_c4_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    bus.awready = 1'b1;
    @(negedge clk);
    chk("aws_c5_bready", {bus.awvalid, bus.bready}, 2'b01);
    @(negedge clk);
    chk("aws_c6_rsp_valid", bus.rsp_valid, 4'b0001);
    @(negedge clk);
    chk("aws_c7_busy", busy, 0);

    // SLVERR write from req1, response withheld five cycles while req2 waits
    set_req(1, 32'h0000_0050, 32'h0000_5151);
    set_req(2, 32'h0000_0060, 32'h0);
    bus.req_write = 4'b0010;
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 4'b0000;
    bus.bresp     = 2'b10;
    bus.rdata     = 32'h600D_0060;
    #1;
    chk("err_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("err_hold%0d_rsp_valid", k), bus.rsp_valid, 4'b0010);
      chk($sformatf("err_hold%0d_rsp_resp", k), bus.rsp_resp, 2'b10);
      chk($sformatf("err_hold%0d_no_grant", k), bus.req_ready, 0);
    end
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    chk("err_after_rsp_valid", bus.rsp_valid, 0);
    chk("err_next_grant", bus.req_ready, 4'b0100);
    bus.rsp_ready = 4'hF;
    @(negedge clk);
    bus.req_valid = '0;
    chk("err_next_araddr", bus.araddr, 32'h0000_0060);
    wait_idle();

    // reset while waiting for R: everything clears and requester 0 regains top priority
    r_en          = 1'b0;
    set_req(0, 32'h0000_0070, 32'h0);
    bus.req_write = 4'b0000;
    bus.req_valid = 4'b0001;
    #1;
    chk("rrd_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("rrd_c2_rready", bus.rready, 1);
    @(negedge clk);
    chk("rrd_c3_rready", bus.rready, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rrd_busy", busy, 0);
    chk("rrd_state", state_dbg, 0);
    chk("rrd_grant_idx", grant_idx, 0);
    chk("rrd_axi_valid_ready", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    chk("rrd_rsp_valid", bus.rsp_valid, 0);
    chk("rrd_araddr", bus.araddr, 0);
    reset = 1'b0;
    r_en  = 1'b1;
    set_req(0, 32'h0000_0090, 32'h0);
    set_req(3, 32'h0000_0093, 32'h0);
    bus.req_valid = 4'b1001;
    #1;
    chk("rrd_prio_req0", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    wait_idle();
    #1;
    chk("rrd_then_req3", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    chk("rrd_req3_araddr", bus.araddr, 32'h0000_0093);
    wait_idle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
